// File: rtl/meas_pkg.sv
// Shared types and constants for the ring-oscillator meter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package meas_pkg;

   // Measurement sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WARM  = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } meas_state_t;

   // Default warm-up length between oscillator enable and counting
   localparam int SETTLE_DEFAULT = 4;

   // Smallest ring that still oscillates, and smallest usable warm-up
   localparam int MIN_STAGES = 3;
   localparam int MIN_SETTLE = 3;

endpackage

// File: rtl/ring_osc_chain.sv
// Enable-gated inverter ring: AND(osc_en, feedback) followed by STAGES inverters.
// Latency: free-running combinational loop; tap is 0 while osc_en is low.
// Backpressure: none. Present only in builds with MEAS_RO_INTERNAL_EN defined.
`ifdef MEAS_RO_INTERNAL_EN
(* keep_hierarchy = "yes", dont_touch = "true" *)
module ring_osc_chain #(
   parameter int STAGES = 5
) (
   input  logic osc_en,
   output logic ro_out
);

   logic [STAGES:0] node;

   // Gate the feedback so a disabled ring parks in a static state
   assign node[0] = osc_en & node[STAGES];

   for (genvar i = 0; i < STAGES; i++) begin : g_inv
      assign node[i+1] = ~node[i];
   end

   // Tap after an even number of inversions so the stopped ring reads 0
   assign ro_out = node[STAGES-1];

endmodule
`endif

// File: rtl/ring_osc_meter.sv
// Ring-oscillator frequency meter: counts prescaled ring edges over a gate window of clk cycles.
// Latency: done pulses SETTLE+gate_len+1 cycles after start is accepted; count held until next done.
// Backpressure: none; start is dropped while busy. Build option MEAS_RO_INTERNAL_EN selects the internal ring over ro_ext.
module ring_osc_meter
   import meas_pkg::*;
#(
   parameter int STAGES   = 5,
   parameter int DIV_LOG2 = 3,
   parameter int CNT_W    = 12,
   parameter int GATE_W   = 10,
   parameter int SETTLE   = SETTLE_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cont,
   input  logic [GATE_W-1:0] gate_len,
   input  logic              ro_ext,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              ro_tap,
   output logic              ro_div
);

   localparam int SETTLE_W = $clog2(SETTLE + 1);
   localparam int TMR_W    = (GATE_W > SETTLE_W) ? GATE_W : SETTLE_W;
   localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);

   if (STAGES < MIN_STAGES || (STAGES % 2) == 0) begin : g_bad_stages
      $error("ring_osc_meter: STAGES must be odd and at least 3");
   end
   if (SETTLE < MIN_SETTLE) begin : g_bad_settle
      $error("ring_osc_meter: SETTLE must be at least 3");
   end

   meas_state_t         state, state_nxt;
   logic [TMR_W-1:0]    tmr, tmr_nxt;
   logic [GATE_W-1:0]   gate_r;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                ovf_r, ovf_nxt;
   logic                osc_en;
   logic                ro_clk;
   logic [DIV_LOG2-1:0] presc;
   logic                sync1, sync2, sync3;
   logic                ro_rise;
   logic                win_end;

   // ---------------- ring domain ----------------
`ifdef MEAS_RO_INTERNAL_EN
   logic ring_out;

   ring_osc_chain #(.STAGES(STAGES)) u_ring (
      .osc_en (osc_en),
      .ro_out (ring_out)
   );

   assign ro_tap = ring_out;
   assign ro_clk = ring_out;
`else
   assign ro_tap = 1'b0;
   assign ro_clk = ro_ext & osc_en;
`endif

   // Prescaler: held at zero whenever the oscillator is disabled, so each window starts in phase
   always_ff @(posedge ro_clk or negedge osc_en) begin
      if (!osc_en) presc <= '0;
      else         presc <= presc + DIV_LOG2'(1);
   end

   // Gate the MSB so the pad reads 0 as soon as osc_en falls
   assign ro_div = presc[DIV_LOG2-1] & osc_en;

   // ---------------- clk domain ----------------
   // Two-flop synchroniser on ro_div plus one history flop for rising-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= ro_div;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign ro_rise = sync2 & ~sync3;
   assign win_end = (state == COUNT) && (tmr == '0);

   // Sequencer next-state and window timer
   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = WARM;
               tmr_nxt   = SETTLE_LD;
            end
         end
         WARM: begin
            if (tmr == '0) begin
               state_nxt = COUNT;
               tmr_nxt   = TMR_W'(gate_r) - TMR_W'(1);
            end else begin
               tmr_nxt = tmr - TMR_W'(1);
            end
         end
         COUNT: begin
            if (tmr == '0) state_nxt = DONE;
            else           tmr_nxt   = tmr - TMR_W'(1);
         end
         DONE: begin
            if (cont) begin
               state_nxt = WARM;
               tmr_nxt   = SETTLE_LD;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Sequencer state, timer, latched gate length and oscillator enable
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         tmr    <= '0;
         gate_r <= '0;
         osc_en <= 1'b0;
      end else begin
         state  <= state_nxt;
         tmr    <= tmr_nxt;
         osc_en <= (state_nxt == WARM) || (state_nxt == COUNT);
         if (state == IDLE && start)
            gate_r <= (gate_len == '0) ? GATE_W'(1) : gate_len;
      end
   end

   // Edge counter: cleared through warm-up, saturating with a sticky flag during the window
   always_comb begin
      cnt_nxt = cnt;
      ovf_nxt = ovf_r;
      if (state == WARM) begin
         cnt_nxt = '0;
         ovf_nxt = 1'b0;
      end else if (state == COUNT && ro_rise) begin
         if (&cnt) ovf_nxt = 1'b1;
         else      cnt_nxt = cnt + CNT_W'(1);
      end
   end

   // Counter state plus result registers, loaded with the final edge of the window included
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         ovf_r    <= 1'b0;
         count    <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         ovf_r <= ovf_nxt;
         done  <= win_end;
         if (win_end) begin
            count    <= cnt_nxt;
            overflow <= ovf_nxt;
         end
      end
   end

   // Busy covers the whole measurement; in continuous mode it stays high through DONE
   assign busy = (state == WARM) || (state == COUNT) || ((state == DONE) && cont);

endmodule

// File: tb/tb_ring_osc_meter.sv
module tb_ring_osc_meter;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       start    = 1'b0;
   logic       start_s  = 1'b0;
   logic       cont     = 1'b0;
   logic       ro_ext   = 1'b0;
   logic [9:0] gate_len = 10'd0;

   logic        busy, done, overflow, ro_tap, ro_div;
   logic [11:0] count;
   logic        busy_s, done_s, overflow_s, ro_tap_s, ro_div_s;
   logic [3:0]  count_s;

   int checks   = 0;
   int failures = 0;
   int ro_half  = 1;
   int ro_ph    = 0;

   ring_osc_meter dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .cont     (cont),
      .gate_len (gate_len),
      .ro_ext   (ro_ext),
      .busy     (busy),
      .done     (done),
      .count    (count),
      .overflow (overflow),
      .ro_tap   (ro_tap),
      .ro_div   (ro_div)
   );

   ring_osc_meter #(.CNT_W(4)) dut_sat (
      .clk      (clk),
      .rst      (rst),
      .start    (start_s),
      .cont     (cont),
      .gate_len (gate_len),
      .ro_ext   (ro_ext),
      .busy     (busy_s),
      .done     (done_s),
      .count    (count_s),
      .overflow (overflow_s),
      .ro_tap   (ro_tap_s),
      .ro_div   (ro_div_s)
   );

   always #5 clk = ~clk;

   // External oscillation source: toggles every ro_half clk cycles
   always @(posedge clk) begin
      #3;
      ro_ph++;
      if (ro_ph >= ro_half) begin
         ro_ph  = 0;
         ro_ext = ~ro_ext;
      end
   end

   // Called at a negedge; returns at the sample point of cycle 1
   task automatic pulse_start(input logic [9:0] g);
      gate_len = g;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic pulse_start_sat(input logic [9:0] g);
      gate_len = g;
      start_s  = 1'b1;
      @(negedge clk);
      start_s  = 1'b0;
   endtask

   // Advance cycle by cycle until done (or done_s) is seen or the budget runs out
   task automatic wait_done(input bit sel_sat, input int budget, inout int cyc, output bit seen);
      seen = sel_sat ? done_s : done;
      while (!seen && cyc < budget) begin
         @(negedge clk);
         cyc++;
         seen = sel_sat ? done_s : done;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; cont = 1'b1; start = 1'b1; start_s = 1'b1; gate_len = 10'd5;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: cycle %0d busy=%b done=%b, expected 0/0", i, busy, done);
         end
      end
      checks++;
      if (count !== 12'd0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_result: count=%0d overflow=%b, expected 0/0", count, overflow);
      end
      checks++;
      if (ro_div !== 1'b0 || ro_tap !== 1'b0) begin
         failures++;
         $display("FAIL reset_ro: ro_div=%b ro_tap=%b, expected 0/0", ro_div, ro_tap);
      end
      checks++;
      if (busy_s !== 1'b0 || count_s !== 4'd0 || overflow_s !== 1'b0) begin
         failures++;
         $display("FAIL reset_sat: busy=%b count=%0d overflow=%b, expected 0/0/0", busy_s, count_s, overflow_s);
      end
      start = 1'b0; start_s = 1'b0; cont = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single;
      int cyc; bit seen; logic [11:0] held;
      repeat (3) @(negedge clk);
      ro_half = 1; cont = 1'b0;
      pulse_start(10'd160);
      cyc = 1;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL single_busy_rise: busy=%b at cycle 1, expected 1", busy);
      end
      wait_done(1'b0, 400, cyc, seen);
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL single_timeout: no done within %0d cycles", cyc);
      end
      checks++;
      if (cyc != 165) begin
         failures++;
         $display("FAIL single_latency: done at cycle %0d, expected 165", cyc);
      end
      checks++;
      if ($isunknown(count) || count < 12'd9 || count > 12'd11) begin
         failures++;
         $display("FAIL single_count: count=%0d, expected 9..11", count);
      end
      checks++;
      if (overflow !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_flags: overflow=%b busy=%b, expected 0/0", overflow, busy);
      end
      held = count;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || count !== held) begin
         failures++;
         $display("FAIL single_hold: done=%b count=%0d, expected 0/%0d", done, count, held);
      end
   endtask

   task automatic test_reset_mid;
      int cyc; bit seen; int pulses;
      repeat (3) @(negedge clk);
      ro_half = 1; cont = 1'b0;
      pulse_start(10'd160);
      cyc = 1;
      while (cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ro_div !== 1'b0 || count !== 12'd0 || done !== 1'b0) begin
         failures++;
         $display("FAIL midrst_state: busy=%b ro_div=%b count=%0d done=%b, expected 0/0/0/0",
                  busy, ro_div, count, done);
      end
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL midrst_nodone: %0d done pulses after reset, expected 0", pulses);
      end
      pulse_start(10'd160);
      cyc = 1;
      wait_done(1'b0, 400, cyc, seen);
      checks++;
      if (!seen || cyc != 165) begin
         failures++;
         $display("FAIL midrst_restart_latency: seen=%b cycle %0d, expected done at 165", seen, cyc);
      end
      checks++;
      if ($isunknown(count) || count < 12'd9 || count > 12'd11) begin
         failures++;
         $display("FAIL midrst_restart_count: count=%0d, expected 9..11", count);
      end
   endtask

   task automatic test_saturation;
      int cyc; bit seen;
      repeat (3) @(negedge clk);
      ro_half = 1; cont = 1'b0;
      pulse_start_sat(10'd1023);
      cyc = 1;
      wait_done(1'b1, 1200, cyc, seen);
      checks++;
      if (!seen || cyc != 1028) begin
         failures++;
         $display("FAIL sat_latency: seen=%b cycle %0d, expected done at 1028", seen, cyc);
      end
      checks++;
      if (count_s !== 4'd15 || overflow_s !== 1'b1) begin
         failures++;
         $display("FAIL sat_result: count=%0d overflow=%b, expected 15/1", count_s, overflow_s);
      end
   endtask

   task automatic test_continuous;
      int cyc; int prev; bit seen; int pulses;
      repeat (3) @(negedge clk);
      ro_half = 2; cont = 1'b1;
      pulse_start(10'd80);
      cyc = 1;
      wait_done(1'b0, 200, cyc, seen);
      checks++;
      if (!seen || cyc != 85) begin
         failures++;
         $display("FAIL cont_first: seen=%b cycle %0d, expected done at 85", seen, cyc);
      end
      checks++;
      if ($isunknown(count) || count < 12'd1 || count > 12'd3 || busy !== 1'b1) begin
         failures++;
         $display("FAIL cont_first_result: count=%0d busy=%b, expected 1..3/1", count, busy);
      end
      for (int k = 0; k < 2; k++) begin
         prev = cyc;
         @(negedge clk);
         cyc++;
         wait_done(1'b0, prev + 200, cyc, seen);
         checks++;
         if (!seen || (cyc - prev) != 85) begin
            failures++;
            $display("FAIL cont_period: seen=%b spacing %0d, expected 85", seen, cyc - prev);
         end
         checks++;
         if ($isunknown(count) || count < 12'd1 || count > 12'd3) begin
            failures++;
            $display("FAIL cont_count: count=%0d, expected 1..3", count);
         end
      end
      prev = cyc;
      @(negedge clk);
      cyc++;
      cont = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL cont_clear_busy: busy=%b after clearing cont, expected 1", busy);
      end
      wait_done(1'b0, prev + 200, cyc, seen);
      checks++;
      if (!seen || (cyc - prev) != 85 || busy !== 1'b0) begin
         failures++;
         $display("FAIL cont_last: seen=%b spacing %0d busy=%b, expected 85/0", seen, cyc - prev, busy);
      end
      pulses = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL cont_idle: %0d extra done pulses busy=%b, expected 0/0", pulses, busy);
      end
   endtask

   task automatic test_gate_zero;
      int cyc; bit seen;
      repeat (3) @(negedge clk);
      ro_half = 1; cont = 1'b0;
      pulse_start(10'd0);
      cyc = 1;
      wait_done(1'b0, 50, cyc, seen);
      checks++;
      if (!seen || cyc != 6) begin
         failures++;
         $display("FAIL gate_zero: seen=%b cycle %0d, expected done at 6", seen, cyc);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL gate_zero_busy: busy=%b at done, expected 0", busy);
      end
   endtask

   task automatic test_start_while_busy;
      int cyc; bit seen; int pulses;
      repeat (3) @(negedge clk);
      ro_half = 1; cont = 1'b0;
      pulse_start(10'd20);
      cyc = 1;
      while (cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      gate_len = 10'd50;
      start    = 1'b1;
      @(negedge clk);
      cyc++;
      start    = 1'b0;
      wait_done(1'b0, 100, cyc, seen);
      checks++;
      if (!seen || cyc != 25) begin
         failures++;
         $display("FAIL busy_start_latency: seen=%b cycle %0d, expected done at 25", seen, cyc);
      end
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_start_dropped: %0d extra done pulses busy=%b, expected 0/0", pulses, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_reset_mid();
      test_saturation();
      test_continuous();
      test_gate_zero();
      test_start_while_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
